// File: rtl/crossbar_pkg.sv
// Shared crossbar definitions: bus widths, command encoding, slave select bit.
// Also holds the slave endpoint FSM state type.
package crossbar_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int SEL_BIT = 31;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_REL
  } slv_state_t;

  function automatic logic [3:0] lat_load(input int lat);
    return 4'(lat);
  endfunction

endpackage

// File: rtl/crossbar_slave_mem_if.sv
// Crossbar slave-port bundle: request side driven by the crossbar,
// ack/rdata/busy returned by the endpoint.
interface crossbar_slave_mem_if
  import crossbar_pkg::*;
#(
  parameter int AW = crossbar_pkg::ADDR_W,
  parameter int DW = crossbar_pkg::DATA_W
);

  logic          req;
  logic          cmd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (
    output req, cmd, addr, wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, cmd, addr, wdata,
    output ack, rdata, busy
  );

endinterface

// File: rtl/crossbar_slave_mem_array.sv
// 1R1W synchronous word array with a registered, resettable read port.
// Storage itself is never reset.
module crossbar_slave_mem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only moves on a read strobe, so rdata holds after ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/crossbar_slave_mem.sv
// Memory-backed crossbar slave with programmable wait states.
// One ack per accepted request; held requests must drop before re-accept.
module crossbar_slave_mem
  import crossbar_pkg::*;
#(
  parameter int ADDR_W     = crossbar_pkg::ADDR_W,
  parameter int DATA_W     = crossbar_pkg::DATA_W,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  crossbar_slave_mem_if.slave  bus
);

  localparam logic [3:0] LAT = lat_load(LATENCY);

  slv_state_t state, nxt;

  logic [3:0]            cnt;
  logic                  cmd_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wd_q;

  logic [DEPTH_LOG2-1:0] idx_in;
  logic                  accept;
  logic                  rd_cmd;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  re;
  logic                  we;

  assign idx_in = bus.addr[DEPTH_LOG2+1:2];
  assign accept = (state == ST_IDLE) && bus.req;

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (bus.req)  nxt = (LAT == 4'd0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (cnt == 4'd1) nxt = ST_ACK;
      ST_ACK:  nxt = bus.req ? ST_REL : ST_IDLE;
      ST_REL:  if (!bus.req) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cmd_q <= CMD_READ;
      idx_q <= '0;
      wd_q  <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt   <= LAT;
        cmd_q <= bus.cmd;
        idx_q <= idx_in;
        wd_q  <= bus.wdata;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // With zero latency the read is issued straight off the bus at accept.
  assign rd_cmd = (state == ST_IDLE) ? bus.cmd : cmd_q;
  assign rd_idx = (state == ST_IDLE) ? idx_in  : idx_q;
  assign re     = (nxt == ST_ACK) && (state != ST_ACK)
                  && (rd_cmd == CMD_READ);
  assign we     = (state == ST_ACK) && (cmd_q == CMD_WRITE);

  crossbar_slave_mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (idx_q),
    .wdata (wd_q),
    .re    (re),
    .raddr (rd_idx),
    .rdata (bus.rdata)
  );

  assign bus.ack  = (state == ST_ACK);
  assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_crossbar_slave_mem.sv
// Bench for crossbar_slave_mem: four instances (latency 2, 2, 0, 15),
// transaction-level model on instance 0, directed literal checks on all.
module tb_crossbar_slave_mem;
  import crossbar_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_v   [4];
  logic        cmd_v   [4];
  logic [31:0] addr_v  [4];
  logic [31:0] wdata_v [4];
  logic        ack_v   [4];
  logic [31:0] rdata_v [4];
  logic        busy_v  [4];

  int lat_v [4] = '{2, 2, 0, 15};

  crossbar_slave_mem_if bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_conn
    assign bus[g].req   = req_v[g];
    assign bus[g].cmd   = cmd_v[g];
    assign bus[g].addr  = addr_v[g];
    assign bus[g].wdata = wdata_v[g];
    assign ack_v[g]     = bus[g].ack;
    assign rdata_v[g]   = bus[g].rdata;
    assign busy_v[g]    = bus[g].busy;
  end

  crossbar_slave_mem #(.LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus[0]));
  crossbar_slave_mem #(.LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus[1]));
  crossbar_slave_mem #(.LATENCY(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(bus[2]));
  crossbar_slave_mem #(.LATENCY(15)) dut_f (
    .clk(clk), .rst_n(rst_n), .bus(bus[3]));

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of instance 0: ack lands LATENCY edges
  // after accept; a request still high at ack must drop before re-accept.
  logic [31:0] mmem [int];
  int          cyc;
  int          m_at;
  bit          m_act, m_rel, m_ack, m_cmd;
  int          m_idx;
  logic [31:0] m_wd;
  logic [31:0] m_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_act = 0; m_rel = 0; m_ack = 0; m_rdata = '0;
    end else begin
      cyc++;
      if (m_ack) begin
        if (m_cmd) mmem[m_idx] = m_wd;
        m_act = 0;
        m_rel = req_v[0];
      end else if (m_rel) begin
        if (!req_v[0]) m_rel = 0;
      end else if (!m_act && req_v[0]) begin
        m_act = 1;
        m_at  = cyc + lat_v[0];
        m_cmd = cmd_v[0];
        m_idx = int'(addr_v[0][9:2]);
        m_wd  = wdata_v[0];
      end
      m_ack = m_act && (cyc == m_at);
      if (m_ack && !m_cmd)
        m_rdata = mmem.exists(m_idx) ? mmem[m_idx] : 32'hx;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_ack",   {31'd0, ack_v[0]},  {31'd0, m_ack});
      chk("model_busy",  {31'd0, busy_v[0]}, {31'd0, m_act || m_rel});
      chk("model_rdata", rdata_v[0], m_rdata);
    end
  end

  task automatic start(int i, bit wr, logic [31:0] a, logic [31:0] d);
    req_v[i]   = 1'b1;
    cmd_v[i]   = wr ? CMD_WRITE : CMD_READ;
    addr_v[i]  = a;
    wdata_v[i] = d;
  endtask

  task automatic drop(int i);
    req_v[i]   = 1'b0;
    addr_v[i]  = $urandom;
    wdata_v[i] = $urandom;
    cmd_v[i]   = 1'($urandom);
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic xfer(int i, bit wr, bit hold, logic [31:0] a,
                      logic [31:0] d, string name,
                      output logic [31:0] rd);
    int k = 0;
    int extra = 0;
    start(i, wr, a, d);
    @(posedge clk); #1;
    if (!hold) drop(i);
    while (k <= 40) begin
      @(negedge clk);
      if (ack_v[i]) break;
      chk({name, "_busy"}, {31'd0, busy_v[i]}, 32'd1);
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_lat"}, k, lat_v[i]);
    rd = rdata_v[i];
    @(posedge clk); #1;
    if (hold) begin
      repeat (3) begin
        @(negedge clk);
        if (ack_v[i]) extra++;
        @(posedge clk); #1;
      end
      chk({name, "_noreack"}, extra, 0);
      drop(i);
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_v[i] = 1'b0; cmd_v[i] = 1'b0;
      addr_v[i] = '0; wdata_v[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_ack",   {31'd0, ack_v[i]},  32'd0);
      chk("rst_busy",  {31'd0, busy_v[i]}, 32'd0);
      chk("rst_rdata", rdata_v[i], 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(0, 1, 0, 32'h7fffffff, 32'h11111111, "t1_wr", rd);
    xfer(0, 0, 0, 32'h7fffffff, 32'h0, "t1_rd", rd);
    chk("t1_rdata", rd, 32'h11111111);

    xfer(0, 0, 1, 32'h7fffffff, 32'h0, "t2_rd", rd);
    chk("t2_rdata", rd, 32'h11111111);

    xfer(0, 1, 0, 32'h000003fc, 32'h22221111, "t3_wr_ff", rd);
    xfer(0, 1, 0, 32'h00000000, 32'h10000001, "t3_wr_00", rd);
    xfer(0, 0, 0, 32'h000003fc, 32'h0, "t3_rd_ff", rd);
    chk("t3_rdata_ff", rd, 32'h22221111);
    xfer(0, 0, 1, 32'h00000000, 32'h0, "t3_rd_00", rd);
    chk("t3_rdata_00", rd, 32'h10000001);
    xfer(0, 0, 0, 32'hfffffffc, 32'h0, "t3_rd_hi", rd);
    chk("t3_rdata_hi", rd, 32'h22221111);

    xfer(2, 1, 0, 32'h00000010, 32'ha5a5a5a5, "t4_l0_wr", rd);
    xfer(2, 0, 1, 32'h00000010, 32'h0, "t4_l0_rd", rd);
    chk("t4_l0_rdata", rd, 32'ha5a5a5a5);
    xfer(3, 1, 0, 32'h00000020, 32'h5a5a0f0f, "t4_l15_wr", rd);
    xfer(3, 0, 0, 32'h00000020, 32'h0, "t4_l15_rd", rd);
    chk("t4_l15_rdata", rd, 32'h5a5a0f0f);

    start(0, 1, 32'h0, 32'hdeadbeef);
    @(posedge clk); #1;
    drop(0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ack",  {31'd0, ack_v[0]},  32'd0);
    chk("t5_busy", {31'd0, busy_v[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 0, 0, 32'h0, 32'h0, "t5_rd", rd);
    chk("t5_rdata", rd, 32'h10000001);

    start(0, 1, 32'h7fffffff, 32'h11111111);
    start(1, 1, 32'hffffffff, 32'h22221111);
    @(posedge clk); #1;
    drop(0); drop(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_ack_a", {31'd0, ack_v[0]}, 32'd1);
    chk("t6_ack_b", {31'd0, ack_v[1]}, 32'd1);
    @(posedge clk); #1;
    xfer(0, 0, 0, 32'h7fffffff, 32'h0, "t6_rd_a", rd);
    chk("t6_rdata_a", rd, 32'h11111111);
    xfer(1, 0, 0, 32'hffffffff, 32'h0, "t6_rd_b", rd);
    chk("t6_rdata_b", rd, 32'h22221111);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
